// File: rtl/dsp_mult_arbiter.sv
// dsp_mult_arbiter
// Round-robin arbiter in front of one shared, fully registered signed
// A_W x B_W multiplier (operand register stage + product register stage).
// Each accepted operand pair returns its product two cycles later on the
// shared result bus, flagged by a one-hot valid addressed to the requester.
// 'hold' freezes the whole pipeline without losing or duplicating results.
module dsp_mult_arbiter #(
   parameter int NREQ = 4,
   parameter int A_W  = 20,
   parameter int B_W  = 18
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      hold,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*A_W-1:0]       req_a,
   input  logic [NREQ*B_W-1:0]       req_b,
   output logic [NREQ-1:0]           req_ready,
   output logic [NREQ-1:0]           rsp_valid,
   output logic signed [A_W+B_W-1:0] rsp_p,
   output logic [15:0]               ops_count,
   output logic                      busy
);

   // Product width is tied to the operand widths and is not a parameter.
   localparam int P_W   = A_W + B_W;
   // Pointer/tag width; a single requester still gets a 1-bit (constant 0) pointer.
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Registered state
   logic [PTR_W-1:0]        ptr_q,       ptr_d;
   logic                    s1_valid_q,  s1_valid_d;
   logic [PTR_W-1:0]        s1_tag_q,    s1_tag_d;
   logic signed [A_W-1:0]   s1_a_q,      s1_a_d;
   logic signed [B_W-1:0]   s1_b_q,      s1_b_d;
   logic                    s2_valid_q,  s2_valid_d;
   logic [PTR_W-1:0]        s2_tag_q,    s2_tag_d;
   logic signed [P_W-1:0]   s2_p_q,      s2_p_d;
   logic [15:0]             ops_q,       ops_d;

   // Arbitration intermediates
   logic [PTR_W:0]          cand_s;
   logic                    found_s;
   logic [PTR_W-1:0]        grant_idx_s;
   logic [PTR_W-1:0]        ptr_next_s;
   logic                    xfer_s;

   // Round-robin search: first valid requester starting at ptr, wrapping modulo NREQ.
   always_comb begin
      found_s     = 1'b0;
      grant_idx_s = '0;
      cand_s      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (cand_s >= (PTR_W+1)'(NREQ)) begin
            cand_s = cand_s - (PTR_W+1)'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req_valid[cand_s[PTR_W-1:0]]) begin
            found_s     = 1'b1;
            grant_idx_s = cand_s[PTR_W-1:0];
         end else begin
            found_s     = found_s;
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // Grant is presented only when not frozen and someone is asking; pointer moves past the winner.
   always_comb begin
      req_ready  = '0;
      xfer_s     = 1'b0;
      ptr_next_s = '0;
      if (grant_idx_s == PTR_W'(NREQ - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = grant_idx_s + PTR_W'(1);
      end
      if (!hold && found_s) begin
         req_ready = onehot(grant_idx_s);
         xfer_s    = 1'b1;
      end else begin
         req_ready = '0;
         xfer_s    = 1'b0;
      end
   end

   // Next-state: capture operands, advance the multiplier, count delivered results; hold freezes all.
   always_comb begin
      ptr_d      = ptr_q;
      s1_valid_d = s1_valid_q;
      s1_tag_d   = s1_tag_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_tag_d   = s2_tag_q;
      s2_p_d     = s2_p_q;
      ops_d      = ops_q;
      if (!hold) begin
         if (xfer_s) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = grant_idx_s;
            s1_a_d     = req_a[int'(grant_idx_s) * A_W +: A_W];
            s1_b_d     = req_b[int'(grant_idx_s) * B_W +: B_W];
            ptr_d      = ptr_next_s;
         end else begin
            s1_valid_d = 1'b0;
         end
         s2_valid_d = s1_valid_q;
         s2_tag_d   = s1_tag_q;
         // Product register only loads real data so rsp_p keeps the last result between results.
         if (s1_valid_q) begin
            s2_p_d = P_W'(s1_a_q) * P_W'(s1_b_q);
         end else begin
            s2_p_d = s2_p_q;
         end
         if (s2_valid_q && (ops_q != 16'hFFFF)) begin
            ops_d = ops_q + 16'd1;
         end else begin
            ops_d = ops_q;
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // State registers; reset discards anything in flight and re-homes the pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_tag_q   <= '0;
         s2_p_q     <= '0;
         ops_q      <= 16'd0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_tag_q   <= s2_tag_d;
         s2_p_q     <= s2_p_d;
         ops_q      <= ops_d;
      end
   end

   // Result valid is suppressed while frozen so each result shows on exactly one live cycle.
   always_comb begin
      rsp_valid = '0;
      if (s2_valid_q && !hold) begin
         rsp_valid = onehot(s2_tag_q);
      end else begin
         rsp_valid = '0;
      end
   end

   assign rsp_p     = s2_p_q;
   assign ops_count = ops_q;
   assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// Directed self-checking bench for dsp_mult_arbiter (NREQ=4, 20x18).
module tb_dsp_mult_arbiter;

   localparam int NREQ = 4;
   localparam int A_W  = 20;
   localparam int B_W  = 18;
   localparam int P_W  = 38;

   logic                clk;
   logic                reset;
   logic                hold;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*A_W-1:0] req_a;
   logic [NREQ*B_W-1:0] req_b;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     rsp_valid;
   logic [P_W-1:0]      rsp_p;
   logic [15:0]         ops_count;
   logic                busy;

   int vectors     = 0;
   int miscompares = 0;

   dsp_mult_arbiter #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_p     (rsp_p),
      .ops_count (ops_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [P_W-1:0] p38(input longint v);
      logic [63:0] t;
      t = v;
      return t[P_W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
      req_valid[i]           = 1'b1;
      req_a[i*A_W +: A_W]    = a;
      req_b[i*B_W +: B_W]    = b;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   logic [3:0] exp_v;

   initial begin
      reset     = 1'b1;
      hold      = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      tick();
      tick();
      #2;
      // Reset state
      chk("rst ready", req_ready, 4'b0000);
      chk("rst rsp_valid", rsp_valid, 4'b0000);
      chk("rst rsp_p", rsp_p, p38(64'sd0));
      chk("rst ops", ops_count, 16'd0);
      chk("rst busy", busy, 1'b0);
      reset = 1'b0;
      tick();

      // Single request: 3 * -5
      req(0, 20'd3, 18'h3FFFB);
      #2; chk("t1 ready", req_ready, 4'b0001);
      tick(); req_valid = '0;
      #2; chk("t1 c1 rsp_valid", rsp_valid, 4'b0000); chk("t1 c1 busy", busy, 1'b1);
      tick();
      #2; chk("t1 c2 rsp_valid", rsp_valid, 4'b0001); chk("t1 c2 rsp_p", rsp_p, p38(-64'sd15));
      tick();
      #2; chk("t1 ops", ops_count, 16'd1); chk("t1 busy", busy, 1'b0);
      tick();

      // All four requesters from reset, A=i+1, B=10; each drops after its grant
      pulse_reset();
      #2; chk("t2 ops after reset", ops_count, 16'd0);
      for (int i = 0; i < NREQ; i++) req(i, 20'(i + 1), 18'd10);
      for (int c = 0; c <= 6; c++) begin
         exp_v = 4'b1111;
         req_valid = (c < 4) ? (exp_v << c) : 4'b0000;
         #2;
         exp_v = 4'b0001;
         if (c < 4) chk("t2 grant", req_ready, exp_v << c);
         else       chk("t2 no grant", req_ready, 4'b0000);
         if (c >= 2 && c <= 5) begin
            chk("t2 rsp_valid", rsp_valid, exp_v << (c - 2));
            chk("t2 rsp_p", rsp_p, p38(longint'((c - 1) * 10)));
         end
         if (c == 6) begin
            chk("t2 busy", busy, 1'b0);
            chk("t2 ops", ops_count, 16'd4);
         end
         tick();
      end

      // Signed corners, back-to-back from r0 (ptr is 0 here)
      req(0, 20'h80000, 18'h20000);
      #2; chk("t3 ready0", req_ready, 4'b0001);
      tick();
      req(0, 20'h00000, 18'h3FFFF);
      #2; chk("t3 ready1", req_ready, 4'b0001);
      tick();
      req(0, 20'h7FFFF, 18'h20000);
      #2; chk("t3 rsp_valid a", rsp_valid, 4'b0001);
      chk("t3 min*min", rsp_p, 38'h10_0000_0000);
      tick(); req_valid = '0;
      #2; chk("t3 rsp_valid b", rsp_valid, 4'b0001); chk("t3 zero", rsp_p, p38(64'sd0));
      tick();
      #2; chk("t3 max*min", rsp_p, p38(-64'sd68719345664));
      tick();
      #2; chk("t3 idle rsp_valid", rsp_valid, 4'b0000);
      chk("t3 rsp_p held", rsp_p, p38(-64'sd68719345664));
      tick();

      // Hold for 3 cycles after the second acceptance (ptr is 1 here)
      req(1, 20'd11, 18'd2);
      #2; chk("t4 acc0", req_ready, 4'b0010);
      tick();
      req(1, 20'd12, 18'd2);
      #2; chk("t4 acc1", req_ready, 4'b0010);
      tick();
      hold = 1'b1;
      req(1, 20'd13, 18'd2);
      for (int h = 0; h < 3; h++) begin
         #2;
         chk("t4 hold ready", req_ready, 4'b0000);
         chk("t4 hold rsp_valid", rsp_valid, 4'b0000);
         tick();
      end
      hold = 1'b0;
      #2; chk("t4 rel ready", req_ready, 4'b0010);
      chk("t4 rel rsp_valid", rsp_valid, 4'b0010); chk("t4 rel p22", rsp_p, p38(64'sd22));
      tick(); req_valid = '0;
      #2; chk("t4 rsp_valid 2", rsp_valid, 4'b0010); chk("t4 p24", rsp_p, p38(64'sd24));
      tick();
      #2; chk("t4 rsp_valid 3", rsp_valid, 4'b0010); chk("t4 p26", rsp_p, p38(64'sd26));
      tick();
      #2; chk("t4 drained", rsp_valid, 4'b0000); chk("t4 busy", busy, 1'b0);
      chk("t4 ops", ops_count, 16'd10);
      tick();

      // Reset mid-flight (ptr is 2 here, so r0 alone wins after wrap)
      req(0, 20'd5, 18'd5);
      #2; chk("t5 acc r0", req_ready, 4'b0001);
      tick(); req_valid = '0;
      req(1, 20'd6, 18'd6);
      #2; chk("t5 acc r1", req_ready, 4'b0010);
      tick(); req_valid = '0;
      reset = 1'b1;
      #2; chk("t5 rst rsp_valid", rsp_valid, 4'b0000); chk("t5 rst busy", busy, 1'b0);
      chk("t5 rst ops", ops_count, 16'd0); chk("t5 rst rsp_p", rsp_p, p38(64'sd0));
      tick(); reset = 1'b0;
      req(0, 20'd1, 18'd1);
      req(2, 20'd7, 18'd6);
      #2; chk("t5 ptr home", req_ready, 4'b0001); chk("t5 no stale 0", rsp_valid, 4'b0000);
      tick(); req_valid[0] = 1'b0;
      #2; chk("t5 r2 grant", req_ready, 4'b0100); chk("t5 no stale 1", rsp_valid, 4'b0000);
      tick(); req_valid = '0;
      #2; chk("t5 rsp r0", rsp_valid, 4'b0001); chk("t5 p1", rsp_p, p38(64'sd1));
      tick();
      #2; chk("t5 rsp r2", rsp_valid, 4'b0100); chk("t5 p42", rsp_p, p38(64'sd42));
      tick();
      #2; chk("t5 ops", ops_count, 16'd2);
      tick();

      // Fairness: park ptr at 1 via r0, then r1 and r3 request continuously
      req(0, 20'd0, 18'd0);
      #2; chk("t6 r0", req_ready, 4'b0001);
      tick(); req_valid = '0;
      req(1, 20'd2, 18'd3);
      req(3, 20'hFFFFE, 18'd3);
      #2; chk("t6 g1 a", req_ready, 4'b0010);
      tick();
      #2; chk("t6 g3 a", req_ready, 4'b1000);
      chk("t6 rsp r0", rsp_valid, 4'b0001); chk("t6 p0", rsp_p, p38(64'sd0));
      tick();
      #2; chk("t6 g1 b", req_ready, 4'b0010);
      chk("t6 rsp r1 a", rsp_valid, 4'b0010); chk("t6 p6 a", rsp_p, p38(64'sd6));
      tick();
      #2; chk("t6 g3 b", req_ready, 4'b1000);
      chk("t6 rsp r3 a", rsp_valid, 4'b1000); chk("t6 pm6 a", rsp_p, p38(-64'sd6));
      tick(); req_valid = '0;
      #2; chk("t6 rsp r1 b", rsp_valid, 4'b0010); chk("t6 p6 b", rsp_p, p38(64'sd6));
      tick();
      #2; chk("t6 rsp r3 b", rsp_valid, 4'b1000); chk("t6 pm6 b", rsp_p, p38(-64'sd6));
      tick();
      #2; chk("t6 ops", ops_count, 16'd7);
      tick();

      // Saturation: 65534 results, then 3 more
      pulse_reset();
      req(0, 20'd1, 18'd1);
      repeat (65534) tick();
      req_valid = '0;
      repeat (3) tick();
      #2; chk("t7 ops 65534", ops_count, 16'hFFFE);
      tick();
      req(0, 20'd1, 18'd1);
      repeat (3) tick();
      req_valid = '0;
      repeat (3) tick();
      #2; chk("t7 ops sat", ops_count, 16'hFFFF); chk("t7 busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
